// File: rtl/irrig_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// irrig_cycle_ctrl
//
// Purpose:
//   Runs one timed irrigation cycle over up to four zones once the upstream
//   initialization FSM reports ready (H1). A cycle consists of a pump prime,
//   then for each zone requested at trigger time a scan, an irrigation window
//   and a closed-valve gap, and finally a cooldown before a new trigger is
//   accepted. Rain (Chuva) or loss of H1 aborts to IDLE; a hydraulic fault
//   (Falha) latches the FAULT state until both Falha and H1 are low.
//   All outputs are registered and derived from the next-state values, so
//   they change only on the clock edge (or on the asynchronous reset).
//
// Ports:
//   Ck     in   clock, rising edge active
//   Clr    in   asynchronous active-low reset
//   H1     in   initialization complete, 1 = system ready
//   Seco   in   [3:0] per-zone dry-soil flag, 1 = zone needs water
//   Chuva  in   rain inhibit, 1 = abort/hold
//   Falha  in   hydraulic fault
//   Bomba  out  pump enable
//   V      out  [3:0] valve enables, one-hot or zero
//   Zona   out  [1:0] index of the active/last served zone
//   Ciclo  out  busy (PRIME, SCAN, IRRIG, GAP)
//   Fim    out  one-cycle pulse on normal cycle completion
//   Erro   out  fault latched
// -----------------------------------------------------------------------------
module irrig_cycle_ctrl #(
    parameter int T_PRIME = 3,
    parameter int T_IRR   = 8,
    parameter int T_GAP   = 2,
    parameter int T_REST  = 4,
    parameter int CW      = 8
) (
    input  logic       Ck,
    input  logic       Clr,
    input  logic       H1,
    input  logic [3:0] Seco,
    input  logic       Chuva,
    input  logic       Falha,
    output logic       Bomba,
    output logic [3:0] V,
    output logic [1:0] Zona,
    output logic       Ciclo,
    output logic       Fim,
    output logic       Erro
);

    // Terminal counter values for each timed state.
    localparam logic [CW-1:0] PRIME_LAST = CW'(T_PRIME - 1);
    localparam logic [CW-1:0] IRR_LAST   = CW'(T_IRR - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);
    localparam logic [CW-1:0] REST_LAST  = CW'(T_REST - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_SCAN,
        S_IRRIG,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg,   cnt_next;
    logic [3:0]    req_reg,   req_next;
    logic [1:0]    idx_reg,   idx_next;
    logic [1:0]    zone_reg,  zone_next;

    logic          bomba_reg, bomba_next;
    logic [3:0]    v_reg,     v_next;
    logic          ciclo_reg, ciclo_next;
    logic          fim_reg,   fim_next;
    logic          erro_reg,  erro_next;

    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand;
    logic          found;
    logic [1:0]    found_idx;
    logic          busy_next;

    // Saturating increment: the counter is cleared on every state entry, so
    // saturation only matters if a parameter exceeds the counter range.
    assign cnt_inc = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

    // Candidate zones for the scan: still requested and not below the
    // position of the last served zone.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = req_reg[gi] && (idx_reg <= 2'(gi));
        end
    endgenerate

    // Lowest-index candidate wins (loop runs high to low, last hit kept).
    always_comb begin
        found     = 1'b0;
        found_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) begin
                found     = 1'b1;
                found_idx = 2'(i);
            end
        end
    end

    // Next-state logic with abort priority: fault, then loss of H1 or rain.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_inc;
        req_next   = req_reg;
        idx_next   = idx_reg;
        zone_next  = zone_reg;

        if (state_reg != S_FAULT && Falha) begin
            state_next = S_FAULT;
            cnt_next   = '0;
            req_next   = 4'd0;
            idx_next   = 2'd0;
            zone_next  = 2'd0;
        end else if (state_reg != S_FAULT && (!H1 || Chuva)) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            req_next   = 4'd0;
            idx_next   = 2'd0;
            zone_next  = 2'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cnt_next = '0;
                    if (Seco != 4'd0) begin
                        state_next = S_PRIME;
                        req_next   = Seco;
                        idx_next   = 2'd0;
                        zone_next  = 2'd0;
                    end
                end
                S_PRIME: begin
                    if (cnt_reg == PRIME_LAST) begin
                        state_next = S_SCAN;
                        cnt_next   = '0;
                    end
                end
                S_SCAN: begin
                    cnt_next = '0;
                    if (found) begin
                        state_next = S_IRRIG;
                        zone_next  = found_idx;
                        idx_next   = found_idx;
                    end else begin
                        state_next = S_DONE;
                    end
                end
                S_IRRIG: begin
                    // Seco is sampled live so a zone that becomes wet closes
                    // early, even on its first open cycle.
                    if (cnt_reg == IRR_LAST || !Seco[zone_reg]) begin
                        state_next         = S_GAP;
                        cnt_next           = '0;
                        req_next[zone_reg] = 1'b0;
                    end
                end
                S_GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_next = S_SCAN;
                        cnt_next   = '0;
                    end
                end
                S_DONE: begin
                    // Triggers are ignored for the whole cooldown window.
                    if (cnt_reg == REST_LAST) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                        zone_next  = 2'd0;
                    end
                end
                S_FAULT: begin
                    cnt_next = '0;
                    // Requiring H1 low forces the upstream init FSM to rerun.
                    if (!Falha && !H1) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    req_next   = 4'd0;
                    idx_next   = 2'd0;
                    zone_next  = 2'd0;
                end
            endcase
        end
    end

    // Output decode from the next-state values, registered below.
    assign busy_next  = (state_next == S_PRIME) || (state_next == S_SCAN) ||
                        (state_next == S_IRRIG) || (state_next == S_GAP);
    assign bomba_next = busy_next;
    assign ciclo_next = busy_next;
    assign fim_next   = (state_next == S_DONE) && (state_reg != S_DONE);
    assign erro_next  = (state_next == S_FAULT);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_valve
            assign v_next[gi] = (state_next == S_IRRIG) && (zone_next == 2'(gi));
        end
    endgenerate

    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            req_reg   <= 4'd0;
            idx_reg   <= 2'd0;
            zone_reg  <= 2'd0;
            bomba_reg <= 1'b0;
            v_reg     <= 4'd0;
            ciclo_reg <= 1'b0;
            fim_reg   <= 1'b0;
            erro_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            idx_reg   <= idx_next;
            zone_reg  <= zone_next;
            bomba_reg <= bomba_next;
            v_reg     <= v_next;
            ciclo_reg <= ciclo_next;
            fim_reg   <= fim_next;
            erro_reg  <= erro_next;
        end
    end

    assign Bomba = bomba_reg;
    assign V     = v_reg;
    assign Zona  = zone_reg;
    assign Ciclo = ciclo_reg;
    assign Fim   = fim_reg;
    assign Erro  = erro_reg;

endmodule

// File: tb/tb_irrig_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irrig_cycle_ctrl
//
// Drives directed scenarios followed by randomized traffic into
// irrig_cycle_ctrl and compares every cycle against a reference model built
// around a queue of zones to visit and a per-phase countdown.
// -----------------------------------------------------------------------------
module tb_irrig_cycle_ctrl;

    localparam int T_PRIME = 3;
    localparam int T_IRR   = 8;
    localparam int T_GAP   = 2;
    localparam int T_REST  = 4;

    logic       Ck = 1'b0;
    logic       Clr;
    logic       H1;
    logic [3:0] Seco;
    logic       Chuva;
    logic       Falha;
    logic       Bomba;
    logic [3:0] V;
    logic [1:0] Zona;
    logic       Ciclo;
    logic       Fim;
    logic       Erro;

    irrig_cycle_ctrl #(
        .T_PRIME(T_PRIME),
        .T_IRR  (T_IRR),
        .T_GAP  (T_GAP),
        .T_REST (T_REST),
        .CW     (8)
    ) dut (
        .Ck   (Ck),
        .Clr  (Clr),
        .H1   (H1),
        .Seco (Seco),
        .Chuva(Chuva),
        .Falha(Falha),
        .Bomba(Bomba),
        .V    (V),
        .Zona (Zona),
        .Ciclo(Ciclo),
        .Fim  (Fim),
        .Erro (Erro)
    );

    always #5 Ck = ~Ck;

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_SCAN  = 2;
    localparam int M_IRRIG = 3;
    localparam int M_GAP   = 4;
    localparam int M_DONE  = 5;
    localparam int M_FAULT = 6;

    int ph;
    int left;
    int cur;
    int last;
    bit fim_m;
    int zq[$];

    function automatic void model_reset();
        ph    = M_IDLE;
        left  = 0;
        cur   = 0;
        last  = 0;
        fim_m = 1'b0;
        zq.delete();
    endfunction

    // One clock edge worth of behaviour, using the inputs present at the edge.
    function automatic void model_step();
        fim_m = 1'b0;
        if (!Clr) begin
            model_reset();
        end else if (ph != M_FAULT && Falha) begin
            ph = M_FAULT;
            zq.delete();
            last = 0;
        end else if (ph != M_FAULT && (!H1 || Chuva)) begin
            ph = M_IDLE;
            zq.delete();
            last = 0;
        end else begin
            case (ph)
                M_IDLE: if (Seco != 4'd0) begin
                    zq.delete();
                    for (int i = 0; i < 4; i++) if (Seco[i]) zq.push_back(i);
                    ph   = M_PRIME;
                    left = T_PRIME;
                    last = 0;
                end
                M_PRIME: begin
                    left--;
                    if (left == 0) ph = M_SCAN;
                end
                M_SCAN: begin
                    if (zq.size() > 0) begin
                        cur  = zq.pop_front();
                        last = cur;
                        ph   = M_IRRIG;
                        left = T_IRR;
                    end else begin
                        ph    = M_DONE;
                        left  = T_REST;
                        fim_m = 1'b1;
                    end
                end
                M_IRRIG: begin
                    left--;
                    if (left == 0 || !Seco[cur]) begin
                        ph   = M_GAP;
                        left = T_GAP;
                    end
                end
                M_GAP: begin
                    left--;
                    if (left == 0) ph = M_SCAN;
                end
                M_DONE: begin
                    left--;
                    if (left == 0) begin
                        ph   = M_IDLE;
                        last = 0;
                    end
                end
                M_FAULT: if (!Falha && !H1) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    endfunction

    function automatic logic [9:0] exp_vec();
        logic       busy;
        logic [3:0] v_e;
        logic [1:0] z_e;
        busy = (ph == M_PRIME) || (ph == M_SCAN) || (ph == M_IRRIG) || (ph == M_GAP);
        v_e  = (ph == M_IRRIG) ? 4'(1 << cur) : 4'd0;
        z_e  = (ph == M_IDLE || ph == M_FAULT) ? 2'd0 : 2'(last);
        return {busy, v_e, z_e, busy, fim_m, (ph == M_FAULT)};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {Bomba, V, Zona, Ciclo, Fim, Erro};
    endfunction

    task automatic step(input string tag);
        @(posedge Ck);
        model_step();
        @(negedge Ck);
        check(tag, 32'(obs_vec()), 32'(exp_vec()));
        $display("cyc t=%0t %s H1=%0b Seco=%b Chuva=%0b Falha=%0b -> Bomba=%0b V=%b Zona=%0d Ciclo=%0b Fim=%0b Erro=%0b",
                 $time, tag, H1, Seco, Chuva, Falha, Bomba, V, Zona, Ciclo, Fim, Erro);
    endtask

    int ciclo_n;
    int fim_n;
    int v_n;
    int k;
    bit hit;

    initial begin
        Clr = 1'b0; H1 = 1'b0; Seco = 4'd0; Chuva = 1'b0; Falha = 1'b0;
        model_reset();
        repeat (2) @(negedge Ck);
        check("reset", 32'(obs_vec()), 32'(exp_vec()));
        Clr = 1'b1;

        // Ready but nothing dry: stays idle.
        H1 = 1'b1;
        repeat (10) step("idle_noseco");

        // Two-zone full cycle.
        Seco = 4'b0101; ciclo_n = 0; fim_n = 0;
        for (int i = 0; i < 60 && fim_n == 0; i++) begin
            step("two_zone");
            if (Ciclo) ciclo_n++;
            if (Fim) fim_n++;
        end
        check("two_zone_ciclo", 32'(ciclo_n), 32'd26);
        check("two_zone_fim", 32'(fim_n), 32'd1);

        // Trigger held during cooldown is only accepted once IDLE is reached.
        Seco = 4'b1111; k = 0; hit = 0;
        for (int i = 1; i <= 12 && !hit; i++) begin
            step("rest_ignore");
            if (Bomba) begin hit = 1; k = i; end
        end
        check("rest_accept_step", 32'(k), 32'd5);

        // Abort via H1, then single zone with early wet exit on 3rd cycle.
        H1 = 1'b0; step("abort_h1");
        H1 = 1'b1; Seco = 4'b0001; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step("wet_wait");
            if (V == 4'b0001) hit = 1;
        end
        check("wet_reached", 32'(hit), 32'd1);
        v_n = 1;
        step("wet_irr"); if (V == 4'b0001) v_n++;
        step("wet_irr"); if (V == 4'b0001) v_n++;
        Seco = 4'b0000;
        step("wet_exit");
        check("wet_irr_cycles", 32'(v_n), 32'd3);
        check("wet_valve_closed", 32'(V), 32'd0);
        fim_n = 0;
        for (int i = 0; i < 20 && fim_n == 0; i++) begin
            step("wet_done");
            if (Fim) fim_n++;
        end
        check("wet_fim", 32'(fim_n), 32'd1);

        // Rain during zone 2 irrigation.
        Seco = 4'b0100; hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step("rain_wait");
            if (V == 4'b0100) hit = 1;
        end
        check("rain_reached", 32'(hit), 32'd1);
        Chuva = 1'b1; step("rain_abort");
        check("rain_bomba", 32'(Bomba), 32'd0);
        check("rain_fim", 32'(Fim), 32'd0);
        Chuva = 1'b0; step("rain_restart");
        check("rain_restart_bomba", 32'(Bomba), 32'd1);

        // Fault in GAP.
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step("fault_wait");
            if (ph == M_GAP) hit = 1;
        end
        check("fault_gap_reached", 32'(hit), 32'd1);
        Falha = 1'b1; step("fault_set");
        check("fault_erro", 32'(Erro), 32'd1);
        Falha = 1'b0; step("fault_hold"); step("fault_hold");
        check("fault_hold_erro", 32'(Erro), 32'd1);
        H1 = 1'b0; step("fault_release");
        check("fault_release_erro", 32'(Erro), 32'd0);
        H1 = 1'b1;

        // Asynchronous reset mid-irrigation.
        Seco = 4'b0001; hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step("areset_wait");
            if (V == 4'b0001) hit = 1;
        end
        check("areset_reached", 32'(hit), 32'd1);
        #1 Clr = 1'b0;
        #1;
        model_reset();
        check("areset_async", 32'(obs_vec()), 32'(exp_vec()));
        step("areset_hold"); step("areset_hold");
        Clr = 1'b1; Seco = 4'b0000;
        repeat (3) step("areset_idle");
        Seco = 4'b0001; step("areset_retrigger");

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            H1    = ($urandom_range(0, 59) != 0);
            Chuva = ($urandom_range(0, 89) == 0);
            if (Falha) Falha = ($urandom_range(0, 5) != 0);
            else       Falha = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) Seco = 4'($urandom_range(0, 15));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/irrig_cycle_ctrl.md
Name: irrig_cycle_ctrl

Overview:
Downstream stage of the initialization FSM. It consumes the init-complete flag H1 and runs one timed irrigation cycle over up to four zones, gated by per-zone dry-soil sensors. It drives the pump and one-hot valve outputs, and aborts on rain or fault. All outputs are registered (Moore) and decoded from the state/counter registers.

Parameters:
T_PRIME, 3, pump-prime cycles with all valves closed before the first zone
T_IRR, 8, maximum cycles a zone valve stays open
T_GAP, 2, cycles with all valves closed between zones (pump stays on)
T_REST, 4, cooldown cycles after a completed cycle before a new trigger is accepted
CW, 8, counter width; must satisfy 2^CW > max(T_PRIME, T_IRR, T_GAP, T_REST)

Ports:
Ck  in  1  clock, rising edge active
Clr  in  1  asynchronous, active-low reset
H1  in  1  initialization complete (from init FSM); 1 = system ready
Seco  in  4  per-zone dry-soil flag; 1 = zone needs water
Chuva  in  1  rain inhibit; 1 = abort/hold
Falha  in  1  hydraulic fault
Bomba  out  1  pump enable
V  out  4  valve enables, one-hot or zero
Zona  out  2  index of the active/last zone
Ciclo  out  1  busy; high in PRIME, SCAN, IRRIG, GAP
Fim  out  1  one-cycle pulse when a cycle completes normally
Erro  out  1  fault latched

Behaviour:
- One clock (Ck). Reset is asynchronous and active-low (Clr=0): state=IDLE; counter=0; req=0; idx=0; Bomba=0, V=0, Zona=0, Ciclo=0, Fim=0, Erro=0.
- Abort priority, evaluated every cycle in every non-FAULT state: Falha=1 -> FAULT; else H1=0 -> IDLE; else Chuva=1 -> IDLE; else normal transition.
- An abort never asserts Fim. It clears req, closes all valves and stops the pump on the next edge.
- IDLE: all outputs 0.
  - If H1=1, Chuva=0, Falha=0 and Seco!=0: req<=Seco, idx<=0, cnt<=0, go to PRIME.
  - If Seco=0, remain in IDLE.
- PRIME: Bomba=1, V=0. cnt increments each cycle; at cnt==T_PRIME-1 go to SCAN. The pump is on for exactly T_PRIME cycles.
- SCAN (1 cycle): Bomba=1, V=0.
  - Select the lowest i>=idx with req[i]=1. If found: Zona<=i, idx<=i, cnt<=0, go to IRRIG.
  - If none: go to DONE, cnt<=0.
- IRRIG: Bomba=1, V=one-hot(Zona).
  - Exit when cnt==T_IRR-1 or Seco[Zona]==0 (early wet exit; checked every IRRIG cycle, including the first).
  - On exit: req[Zona]<=0, cnt<=0, go to GAP.
- GAP: Bomba=1, V=0. After T_GAP cycles go to SCAN. V never changes directly from one zone to another; at least T_GAP+1 zero-valve cycles separate zones.
- DONE: Fim=1 for the first cycle only. Bomba=0, V=0, Ciclo=0. Hold T_REST cycles ignoring triggers, then go to IDLE.
- FAULT: Erro=1, all other outputs 0. Leave to IDLE only when Falha=0 and H1=0 in the same cycle, which forces re-initialization upstream.
- Seco is sampled live in IRRIG for early exit. The req mask captured at trigger decides which zones are visited; zones that become dry mid-cycle wait for the next cycle.
- Counter saturates/clears per state and never wraps inside a state.
- Zona holds the last served zone outside IRRIG.

Test Plan:
(all with T_PRIME=3, T_IRR=8, T_GAP=2, T_REST=4)
1. Clr=0 pulsed mid-IRRIG (V=0001) -> asynchronously V=0, Bomba=0, Ciclo=0, Erro=0. After release, stays IDLE until H1=1 and Seco!=0.
2. H1=1, Seco=0101 held -> Bomba high edge+1. Sequence: 3 PRIME, 1 SCAN, V=0001 for 8 cycles, 2 GAP, 1 SCAN, V=0100 for 8, 2 GAP, 1 SCAN, then Fim=1 for 1 cycle and Bomba=0. Total Ciclo-high cycles = 26.
3. Seco=0001, Seco[0] drops to 0 during the 3rd IRRIG cycle -> V[0] falls on the next edge (3 IRRIG cycles total); GAP, SCAN, DONE follow with Fim=1.
4. Chuva=1 during IRRIG of zone 2 -> next edge: V=0, Bomba=0, state IDLE, Fim never pulses. Chuva=0 with Seco=0100 -> restarts from PRIME.
5. Falha=1 in GAP -> Erro=1, all else 0. Falha=0 with H1=1 keeps Erro=1. H1=0 then releases to IDLE with Erro=0.
6. H1=1, Seco=0000 for 10 cycles -> Bomba, V, Ciclo stay 0. After DONE, Seco=1111 during the 4 REST cycles is ignored; trigger is accepted on the 5th cycle.
